// File: rtl/quad_operand_collector_if.sv
// Handshake bundle between the operand collector and its producer/consumer.
// The collector side is "slave"; the feeding/consuming environment is "master".
interface quad_operand_collector_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             quad_valid;
    logic             quad_ready;
    logic [2:0]       fill;

    modport slave (
        input  in_data, in_valid, quad_ready,
        output in_ready, a, b, c, d, quad_valid, fill
    );

    modport master (
        output in_data, in_valid, quad_ready,
        input  in_ready, a, b, c, d, quad_valid, fill
    );
endinterface

// File: rtl/quad_operand_collector.sv
// Gathers a serial valid/ready word stream into parallel quads a..d for the
// four-operand adder; holds each quad until downstream accepts it.
//
// state   | meaning
// COLLECT | accepting words into slot r_idx (0..3), in_ready high unless clear
// FULL    | quad presented on a..d, in_ready follows quad_ready
module quad_operand_collector #(
    parameter int WIDTH = 4
) (
    input logic                      clk,
    input logic                      rst,
    input logic                      i_clear,
    quad_operand_collector_if.slave  bus
);
    typedef enum logic {
        S_COLLECT = 1'b0,
        S_FULL    = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_d;
    logic             r_quad_valid;
    logic [2:0]       r_fill;

    logic w_in_ready;
    logic w_in_fire;
    logic w_out_fire;

    // In FULL a new word is only taken when the held quad leaves this cycle.
    assign w_in_ready = !rst && !i_clear && ((r_state == S_COLLECT) || bus.quad_ready);
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = r_quad_valid && bus.quad_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_COLLECT;
            r_idx        <= 2'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_d          <= '0;
            r_quad_valid <= 1'b0;
            r_fill       <= 3'd0;
        end else if (i_clear) begin
            r_state      <= S_COLLECT;
            r_idx        <= 2'd0;
            r_quad_valid <= 1'b0;
            r_fill       <= 3'd0;
        end else if (r_state == S_COLLECT) begin
            if (w_in_fire) begin
                unique case (r_idx)
                    2'd0:    r_a <= bus.in_data;
                    2'd1:    r_b <= bus.in_data;
                    2'd2:    r_c <= bus.in_data;
                    default: r_d <= bus.in_data;
                endcase
                if (r_idx == 2'd3) begin
                    r_state      <= S_FULL;
                    r_idx        <= 2'd0;
                    r_quad_valid <= 1'b1;
                    r_fill       <= 3'd4;
                end else begin
                    r_idx  <= r_idx + 2'd1;
                    r_fill <= {1'b0, r_idx} + 3'd1;
                end
            end
        end else begin
            if (w_out_fire) begin
                r_state      <= S_COLLECT;
                r_quad_valid <= 1'b0;
                // Back-to-back: the word arriving with the output handshake starts the next quad.
                if (w_in_fire) begin
                    r_a    <= bus.in_data;
                    r_idx  <= 2'd1;
                    r_fill <= 3'd1;
                end else begin
                    r_idx  <= 2'd0;
                    r_fill <= 3'd0;
                end
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.a          = r_a;
    assign bus.b          = r_b;
    assign bus.c          = r_c;
    assign bus.d          = r_d;
    assign bus.quad_valid = r_quad_valid;
    assign bus.fill       = r_fill;
endmodule

// File: tb/tb_quad_operand_collector.sv
// Directed bench for quad_operand_collector: stimulus pushes expected quads into a
// scoreboard queue, an independent monitor pops and compares on each output handshake.
module tb_quad_operand_collector;
    localparam int WIDTH = 4;

    typedef struct {
        int a;
        int b;
        int c;
        int d;
        int e;
    } quad_t;

    logic clk;
    logic rst;
    logic clear;

    quad_operand_collector_if #(.WIDTH(WIDTH)) bus ();

    quad_operand_collector #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_clear (clear),
        .bus     (bus)
    );

    quad_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    hs_count = 0;
    int    pop_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_quad(input int a, input int b, input int c, input int d);
        quad_t q;
        q.a = a; q.b = b; q.c = c; q.d = d; q.e = a + b + c + d;
        exp_q.push_back(q);
    endtask

    task automatic drive(input logic v, input int data, input logic qr);
        bus.in_valid   = v;
        bus.in_data    = data[WIDTH-1:0];
        bus.quad_ready = qr;
    endtask

    task automatic check_quad(input string name, input int a, input int b, input int c, input int d);
        chk({name, "_a"}, int'(bus.a), a);
        chk({name, "_b"}, int'(bus.b), b);
        chk({name, "_c"}, int'(bus.c), c);
        chk({name, "_d"}, int'(bus.d), d);
    endtask

    // Monitor: counts input handshakes and scores every output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) hs_count++;
            if (bus.quad_valid && bus.quad_ready) begin
                logic [WIDTH+1:0] e_dut;
                quad_t q;
                pop_count++;
                e_dut = {2'b00, bus.a} + {2'b00, bus.b} + {2'b00, bus.c} + {2'b00, bus.d};
                if (exp_q.size() == 0) begin
                    chk("unexpected_quad", 1, 0);
                end else begin
                    q = exp_q.pop_front();
                    chk("mon_a", int'(bus.a), q.a);
                    chk("mon_b", int'(bus.b), q.b);
                    chk("mon_c", int'(bus.c), q.c);
                    chk("mon_d", int'(bus.d), q.d);
                    chk("mon_e", int'(e_dut), q.e);
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int hs0;
        int pop0;
        rst   = 1'b1;
        clear = 1'b0;
        drive(1'b0, 0, 1'b0);
        cycle();
        cycle();
        chk("rst_in_ready", int'(bus.in_ready), 0);
        rst = 1'b0;
        #1;
        chk("rst_quad_valid", int'(bus.quad_valid), 0);
        chk("rst_fill", int'(bus.fill), 0);
        chk("post_rst_in_ready", int'(bus.in_ready), 1);
        check_quad("rst", 0, 0, 0, 0);

        // Basic quad 1,2,3,4
        push_quad(1, 2, 3, 4);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, k, 1'b1);
            cycle();
        end
        drive(1'b0, 0, 1'b1);
        chk("t1_quad_valid", int'(bus.quad_valid), 1);
        chk("t1_fill_full", int'(bus.fill), 4);
        cycle();
        chk("t1_quad_valid_pulse", int'(bus.quad_valid), 0);
        chk("t1_fill_empty", int'(bus.fill), 0);

        // Max values: sum 60 needs the full WIDTH+2 bits
        push_quad(15, 15, 15, 15);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 15, 1'b1);
            cycle();
        end
        drive(1'b0, 0, 1'b1);
        cycle();

        // Backpressure with a pending word
        push_quad(5, 6, 7, 8);
        for (int k = 5; k <= 8; k++) begin
            drive(1'b1, k, 1'b0);
            cycle();
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 9, 1'b0);
            #1;
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_fill", int'(bus.fill), 4);
            chk("bp_quad_valid", int'(bus.quad_valid), 1);
            check_quad("bp_hold", 5, 6, 7, 8);
            cycle();
        end
        drive(1'b1, 9, 1'b1);
        #1;
        chk("bp_release_in_ready", int'(bus.in_ready), 1);
        push_quad(9, 10, 11, 12);
        cycle();
        chk("bp_pending_a", int'(bus.a), 9);
        chk("bp_pending_fill", int'(bus.fill), 1);
        chk("bp_pending_qv", int'(bus.quad_valid), 0);
        for (int k = 10; k <= 12; k++) begin
            drive(1'b1, k, 1'b1);
            cycle();
        end
        drive(1'b0, 0, 1'b1);
        cycle();

        // Back-to-back streaming 0..7
        hs0  = hs_count;
        pop0 = pop_count;
        push_quad(0, 1, 2, 3);
        push_quad(4, 5, 6, 7);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, k, 1'b1);
            #1;
            chk("b2b_in_ready", int'(bus.in_ready), 1);
            cycle();
        end
        drive(1'b0, 0, 1'b1);
        cycle();
        chk("b2b_handshakes", hs_count - hs0, 8);
        chk("b2b_quads", pop_count - pop0, 2);

        // Clear mid-collect
        hs0 = hs_count;
        drive(1'b1, 9, 1'b1);
        cycle();
        drive(1'b1, 10, 1'b1);
        cycle();
        drive(1'b1, 11, 1'b1);
        clear = 1'b1;
        #1;
        chk("clr_in_ready", int'(bus.in_ready), 0);
        cycle();
        clear = 1'b0;
        drive(1'b0, 0, 1'b1);
        #1;
        chk("clr_fill", int'(bus.fill), 0);
        chk("clr_quad_valid", int'(bus.quad_valid), 0);
        chk("clr_a_kept", int'(bus.a), 9);
        chk("clr_b_kept", int'(bus.b), 10);
        push_quad(1, 2, 3, 4);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, k, 1'b1);
            cycle();
        end
        drive(1'b0, 0, 1'b1);
        cycle();
        chk("clr_handshakes", hs_count - hs0, 6);

        // Reset while FULL and stalled
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 3, 1'b0);
            cycle();
        end
        drive(1'b0, 0, 1'b0);
        #1;
        chk("rf_quad_valid_before", int'(bus.quad_valid), 1);
        chk("rf_fill_before", int'(bus.fill), 4);
        rst = 1'b1;
        #1;
        chk("rf_in_ready_in_rst", int'(bus.in_ready), 0);
        cycle();
        rst = 1'b0;
        #1;
        chk("rf_quad_valid", int'(bus.quad_valid), 0);
        chk("rf_fill", int'(bus.fill), 0);
        chk("rf_in_ready", int'(bus.in_ready), 1);
        check_quad("rf", 0, 0, 0, 0);
        cycle();
        cycle();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
